// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types and default constants
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
  localparam int DEF_BAUD_DIV0 = 5208;
  localparam int DEF_BAUD_DIV1 = 2604;
  localparam int DEF_BAUD_DIV2 = 868;
  localparam int DEF_BAUD_DIV3 = 434;
  localparam int UART_FRAME_BITS = 10;
endpackage

// File: rtl/uart_tx_core_fifo.sv
// sync_fifo: first-word-fall-through synchronous FIFO, power-of-2 depth
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign rdata = mem[rp];
  // pointers wrap naturally at DEPTH; count tracks occupancy
  always_ff @(posedge clk)
    if (!rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop) rp <= rp + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  // storage array, no reset needed
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= wdata;
endmodule

// File: rtl/uart_tx_core.sv
// uart_tx_core: buffered 8N1 UART transmitter with selectable baud divider
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int DIV_W = 16,
  parameter int BAUD_DIV0 = DEF_BAUD_DIV0,
  parameter int BAUD_DIV1 = DEF_BAUD_DIV1,
  parameter int BAUD_DIV2 = DEF_BAUD_DIV2,
  parameter int BAUD_DIV3 = DEF_BAUD_DIV3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] wdata,
  input  logic       wen,
  output logic       wready,
  input  logic [1:0] baud,
  input  logic       txen,
  input  logic       txst,
  output logic       busy,
  output logic       busy_en,
  output logic       txf,
  output logic       tx_set,
  output logic       txd
);
  tx_state_t state, state_n;
  logic [DIV_W-1:0] cnt, cnt_n, div, div_n, bdiv;
  logic [7:0] sh, sh_n, rdata;
  logic [2:0] idx, idx_n;
  logic txd_n, busy_n, tx_set_n, push, pop, full, empty, tick, start_ok, load;
  logic [$clog2(DEPTH):0] count;
  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .wdata(wdata),
    .rdata(rdata), .full(full), .empty(empty), .count(count)
  );
  assign wready = ~full;
  assign txf = full;
  assign push = wen & wready;
  assign bdiv = baud == 2'd0 ? DIV_W'(BAUD_DIV0) : baud == 2'd1 ? DIV_W'(BAUD_DIV1) :
                baud == 2'd2 ? DIV_W'(BAUD_DIV2) : DIV_W'(BAUD_DIV3);
  assign tick = cnt == '0;
  assign start_ok = ~empty & (state == IDLE ? (txen | txst) : txen);
  assign load = start_ok & (state == IDLE | (state == STOP & tick));
  // next-state, bit timing and serial data selection
  always_comb begin
    state_n = state;
    cnt_n = state == IDLE ? cnt : tick ? div - DIV_W'(1) : cnt - DIV_W'(1);
    div_n = div;
    sh_n = sh;
    idx_n = idx;
    txd_n = txd;
    tx_set_n = 1'b0;
    pop = 1'b0;
    case (state)
      START: if (tick) begin
        state_n = DATA;
        txd_n = sh[0];
        sh_n = sh >> 1;
        idx_n = '0;
      end
      DATA: if (tick) begin
        state_n = idx == 3'(UART_FRAME_BITS - 3) ? STOP : DATA;
        txd_n = idx == 3'(UART_FRAME_BITS - 3) ? 1'b1 : sh[0];
        sh_n = sh >> 1;
        idx_n = idx + 3'd1;
      end
      STOP: if (tick & ~load) begin
        state_n = IDLE;
        tx_set_n = count == '0 & ~push;
      end
      default: ;
    endcase
    if (load) begin
      pop = 1'b1;
      state_n = START;
      txd_n = 1'b0;
      div_n = bdiv;
      cnt_n = bdiv - DIV_W'(1);
      sh_n = rdata;
    end
    busy_n = state_n != IDLE;
  end
  // state and registered outputs
  always_ff @(posedge clk)
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      div <= '0;
      sh <= '0;
      idx <= '0;
      txd <= 1'b1;
      busy <= 1'b0;
      busy_en <= 1'b0;
      tx_set <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      div <= div_n;
      sh <= sh_n;
      idx <= idx_n;
      txd <= txd_n;
      busy <= busy_n;
      busy_en <= busy_n ^ busy;
      tx_set <= tx_set_n;
    end
endmodule

// File: tb/tb_uart_tx_core.sv
// tb_uart_tx_core: directed self-checking bench for uart_tx_core
module tb_uart_tx_core;
  logic clk = 0, rst = 0, wen = 1, txen = 1, txst = 0;
  logic [7:0] wdata = 8'h55;
  logic [1:0] baud = 2'd3;
  logic wready, busy, busy_en, txf, tx_set, txd;
  int n_chk = 0, n_err = 0, ben_seen = 0, txs_seen = 0, ben0, txs0;
  uart_tx_core #(.DEPTH(8), .DIV_W(16), .BAUD_DIV0(5208), .BAUD_DIV1(2604), .BAUD_DIV2(6), .BAUD_DIV3(4)) dut (
    .clk(clk), .rst(rst), .wdata(wdata), .wen(wen), .wready(wready), .baud(baud), .txen(txen),
    .txst(txst), .busy(busy), .busy_en(busy_en), .txf(txf), .tx_set(tx_set), .txd(txd)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    ben_seen <= ben_seen + int'(busy_en);
    txs_seen <= txs_seen + int'(tx_set);
  end
  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic chk_frame(input logic [7:0] b, input int div, input int from, input int to, input string tag);
    for (int k = from; k < to; k++) begin
      int j;
      logic e;
      j = k / div;
      e = j == 0 ? 1'b0 : j == 9 ? 1'b1 : b[j-1];
      chk($sformatf("%s txd[%0d]", tag, k), txd, e);
      chk($sformatf("%s busy[%0d]", tag, k), busy, 1);
      cyc();
    end
  endtask
  initial begin
    // 1: reset with wen/txen asserted
    cyc(3);
    chk("rst txd", txd, 1);
    chk("rst wready", wready, 1);
    chk("rst txf", txf, 0);
    chk("rst busy", busy, 0);
    chk("rst busy_en", busy_en, 0);
    chk("rst tx_set", tx_set, 0);
    rst = 1; wen = 0;
    cyc(3);
    chk("rst no push", busy, 0);
    // 2: single frame 0xA5 at 4 clk/bit
    wdata = 8'hA5; wen = 1;
    cyc();
    wen = 0;
    chk("t2 idle before start", busy, 0);
    ben0 = ben_seen; txs0 = txs_seen;
    cyc();
    chk("t2 busy_en rise", busy_en, 1);
    chk_frame(8'hA5, 4, 0, 40, "t2");
    chk("t2 end busy", busy, 0);
    chk("t2 end busy_en", busy_en, 1);
    chk("t2 end tx_set", tx_set, 1);
    chk("t2 end txd", txd, 1);
    cyc();
    chk("t2 busy_en drop", busy_en, 0);
    chk("t2 tx_set drop", tx_set, 0);
    cyc();
    chk("t2 busy_en pulses", ben_seen - ben0, 2);
    chk("t2 tx_set pulses", txs_seen - txs0, 1);
    // 3: fill FIFO with txen=0, then txst forces one frame
    txen = 0;
    for (int i = 0; i < 8; i++) begin
      wdata = 8'h10 + 8'(i); wen = 1;
      cyc();
    end
    chk("t3 full txf", txf, 1);
    chk("t3 full wready", wready, 0);
    wdata = 8'h18;
    cyc(3);
    chk("t3 stall txf", txf, 1);
    chk("t3 stall busy", busy, 0);
    txs0 = txs_seen;
    txst = 1;
    cyc();
    txst = 0;
    chk("t3 start busy", busy, 1);
    chk("t3 start txd", txd, 0);
    chk("t3 pop wready", wready, 1);
    chk("t3 pop txf", txf, 0);
    cyc();
    wen = 0;
    chk("t3 9th pushed txf", txf, 1);
    chk("t3 txd", txd, 0);
    cyc(39);
    chk("t3 end busy", busy, 0);
    chk("t3 end tx_set", tx_set, 0);
    cyc(5);
    chk("t3 stays idle", busy, 0);
    chk("t3 still full", txf, 1);
    chk("t3 no tx_set", txs_seen - txs0, 0);
    // 6: reset during DATA discards the queue
    txen = 1;
    cyc();
    chk("t6 start busy", busy, 1);
    wdata = 8'h19; wen = 1;
    cyc();
    wen = 0;
    chk("t6 refill txf", txf, 1);
    cyc(9);
    chk("t6 mid data txd", txd, 0);
    chk("t6 mid data busy", busy, 1);
    txs0 = txs_seen;
    rst = 0;
    cyc();
    chk("t6 rst txd", txd, 1);
    chk("t6 rst busy", busy, 0);
    chk("t6 rst txf", txf, 0);
    chk("t6 rst wready", wready, 1);
    rst = 1;
    cyc(20);
    chk("t6 no resend busy", busy, 0);
    chk("t6 no resend txd", txd, 1);
    chk("t6 no tx_set", txs_seen - txs0, 0);
    // 4: back-to-back 0x01, 0x80
    wdata = 8'h01; wen = 1;
    cyc();
    wdata = 8'h80;
    ben0 = ben_seen; txs0 = txs_seen;
    cyc();
    wen = 0;
    chk_frame(8'h01, 4, 0, 40, "t4a");
    chk_frame(8'h80, 4, 0, 40, "t4b");
    chk("t4 end busy", busy, 0);
    chk("t4 end tx_set", tx_set, 1);
    cyc(2);
    chk("t4 busy_en pulses", ben_seen - ben0, 2);
    chk("t4 tx_set pulses", txs_seen - txs0, 1);
    // 5: baud change mid-frame applies to the next frame only
    wdata = 8'h3C; wen = 1;
    cyc();
    wdata = 8'hC3;
    cyc();
    wen = 0;
    chk_frame(8'h3C, 4, 0, 20, "t5a");
    baud = 2'd2;
    chk_frame(8'h3C, 4, 20, 40, "t5a");
    chk_frame(8'hC3, 6, 0, 60, "t5b");
    chk("t5 end busy", busy, 0);
    chk("t5 end txd", txd, 1);
    chk("t5 end tx_set", tx_set, 1);
    cyc(2);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
